// File: rtl/bira_session_ctrl.sv
// bira_session_ctrl
// Sequences a BIST/BIRA repair session over the spare-structure types selected
// in struct_mask_i, lowest index first. For each structure it drives
// spare_struct_o, pulses bira_clr_o, then bist_start_o, waits for the BIST to
// end (or aborts it), then waits for repair analysis. Solution words from BIRA
// are buffered in a show-ahead FIFO for the host.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, struct_mask_i session request and structure selection
//   spare_struct_o         structure type currently driven to BIRA
//   bira_clr_o             one-cycle clear ahead of each structure
//   bist_start_o           one-cycle BIST launch
//   bist_abort_o           one-cycle BIST stop (early termination or timeout)
//   test_end_i             BIST finished
//   early_term_i           BIRA early termination (unrepairable)
//   ra_done_i, repair_i    analysis finished / repairable flag
//   sol_valid_i, solution_i solution word strobe and data
//   sol_rd_i               host pop
//   sol_dout_o, sol_empty_o, sol_count_o  FIFO head, empty, occupancy
//   busy_o, done_o         session in progress / complete (level)
//   result_o               per-structure repairable bits
//   overflow_o             sticky, a solution word was dropped
//   timeout_err_o          sticky, a BIST or analysis phase timed out
//
// state    | meaning
// IDLE     | waiting for start after reset
// SELECT   | pick lowest selected structure at or above index
// CLEAR    | bira_clr pulse for the chosen structure
// RUN_BIST | BIST running, watch early_term / test_end / timer
// WAIT_RA  | waiting for repair analysis to finish
// DONE     | session complete, start accepted again

module bira_session_ctrl #(
    parameter int SOL_DEPTH = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [3:0]                  struct_mask_i,
    output logic [1:0]                  spare_struct_o,
    output logic                        bira_clr_o,
    output logic                        bist_start_o,
    output logic                        bist_abort_o,
    input  logic                        test_end_i,
    input  logic                        early_term_i,
    input  logic                        ra_done_i,
    input  logic                        repair_i,
    input  logic                        sol_valid_i,
    input  logic [15:0]                 solution_i,
    input  logic                        sol_rd_i,
    output logic [15:0]                 sol_dout_o,
    output logic                        sol_empty_o,
    output logic [$clog2(SOL_DEPTH):0]  sol_count_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [3:0]                  result_o,
    output logic                        overflow_o,
    output logic                        timeout_err_o
);

    localparam int PW = $clog2(SOL_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    // The phase exits on the edge where the timer would reach TIMEOUT-1, so the
    // registered abort pulse appears TIMEOUT-1 cycles after bist_start.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE, SELECT, CLEAR, RUN_BIST, WAIT_RA, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      mask_q, mask_d;
    logic [2:0]      index_q, index_d;
    logic [1:0]      spare_q, spare_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      result_q, result_d;
    logic            timeout_err_q, timeout_err_d;
    logic            bira_clr_q, bira_clr_d;
    logic            bist_start_q, bist_start_d;
    logic            bist_abort_q, bist_abort_d;

    logic            start_acc;
    logic            found;
    logic [1:0]      sel;
    logic [2:0]      next_index;

    assign start_acc  = start_i && (state_q == IDLE || state_q == DONE);
    assign next_index = 3'(spare_q) + 3'd1;

    always_comb begin
        found = 1'b0;
        sel   = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (!found && mask_q[b] && (3'(b) >= index_q)) begin
                found = 1'b1;
                sel   = 2'(b);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        index_d       = index_q;
        spare_d       = spare_q;
        timer_d       = timer_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        bira_clr_d    = 1'b0;
        bist_start_d  = 1'b0;
        bist_abort_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    result_d      = 4'd0;
                    timeout_err_d = 1'b0;
                    if (struct_mask_i != 4'd0) begin
                        mask_d  = struct_mask_i;
                        index_d = 3'd0;
                        state_d = SELECT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SELECT: begin
                if (found) begin
                    spare_d    = sel;
                    bira_clr_d = 1'b1;
                    state_d    = CLEAR;
                end else begin
                    state_d = DONE;
                end
            end
            CLEAR: begin
                bist_start_d = 1'b1;
                timer_d      = '0;
                state_d      = RUN_BIST;
            end
            RUN_BIST: begin
                if (early_term_i) begin
                    bist_abort_d      = 1'b1;
                    result_d[spare_q] = 1'b0;
                    index_d           = next_index;
                    state_d           = SELECT;
                end else if (test_end_i) begin
                    timer_d = '0;
                    state_d = WAIT_RA;
                end else if (timer_q == T_LAST) begin
                    bist_abort_d      = 1'b1;
                    timeout_err_d     = 1'b1;
                    result_d[spare_q] = 1'b0;
                    index_d           = next_index;
                    state_d           = SELECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_RA: begin
                if (ra_done_i) begin
                    result_d[spare_q] = repair_i;
                    index_d           = next_index;
                    state_d           = SELECT;
                end else if (timer_q == T_LAST) begin
                    // Advance past the stuck structure so the session still ends.
                    timeout_err_d     = 1'b1;
                    result_d[spare_q] = 1'b0;
                    index_d           = next_index;
                    state_d           = SELECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            mask_q        <= 4'd0;
            index_q       <= 3'd0;
            spare_q       <= 2'd0;
            timer_q       <= '0;
            result_q      <= 4'd0;
            timeout_err_q <= 1'b0;
            bira_clr_q    <= 1'b0;
            bist_start_q  <= 1'b0;
            bist_abort_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            index_q       <= index_d;
            spare_q       <= spare_d;
            timer_q       <= timer_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
            bira_clr_q    <= bira_clr_d;
            bist_start_q  <= bist_start_d;
            bist_abort_q  <= bist_abort_d;
        end
    end

    // Solution FIFO
    logic [15:0]   mem_q [SOL_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   last_q;
    logic          overflow_q;
    logic          full, empty, rd_en, wr_en, drop;

    assign full  = (count_q == CW'(SOL_DEPTH));
    assign empty = (count_q == '0);
    // A start clears the FIFO; anything strobed in that same cycle is discarded.
    assign rd_en = sol_rd_i && !empty && !start_acc;
    assign wr_en = sol_valid_i && (!full || rd_en) && !start_acc;
    assign drop  = sol_valid_i && full && !rd_en && !start_acc;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= solution_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= 16'd0;
            overflow_q <= 1'b0;
        end else if (start_acc) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + CW'(1);
            end else if (rd_en && !wr_en) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // When empty the output holds the most recently popped word.
    assign sol_dout_o     = empty ? last_q : mem_q[rd_ptr_q];
    assign sol_empty_o    = empty;
    assign sol_count_o    = count_q;
    assign overflow_o     = overflow_q;

    assign spare_struct_o = spare_q;
    assign bira_clr_o     = bira_clr_q;
    assign bist_start_o   = bist_start_q;
    assign bist_abort_o   = bist_abort_q;
    assign busy_o         = (state_q == SELECT) || (state_q == CLEAR) ||
                            (state_q == RUN_BIST) || (state_q == WAIT_RA);
    assign done_o         = (state_q == DONE);
    assign result_o       = result_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_bira_session_ctrl.sv
module tb_bira_session_ctrl;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mask = 4'd0;
    logic        test_end = 1'b0, early_term = 1'b0, ra_done = 1'b0, repair = 1'b0;
    logic        sol_valid = 1'b0, sol_rd = 1'b0;
    logic [15:0] solution = 16'd0;

    logic [1:0]  spare_struct;
    logic        bira_clr, bist_start, bist_abort;
    logic [15:0] sol_dout;
    logic        sol_empty;
    logic [4:0]  sol_count;
    logic        busy, done, overflow, timeout_err;
    logic [3:0]  result;

    int checks = 0;
    int errors = 0;

    bira_session_ctrl #(.SOL_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .struct_mask_i(mask),
        .spare_struct_o(spare_struct), .bira_clr_o(bira_clr),
        .bist_start_o(bist_start), .bist_abort_o(bist_abort),
        .test_end_i(test_end), .early_term_i(early_term), .ra_done_i(ra_done),
        .repair_i(repair), .sol_valid_i(sol_valid), .solution_i(solution),
        .sol_rd_i(sol_rd), .sol_dout_o(sol_dout), .sol_empty_o(sol_empty),
        .sol_count_o(sol_count), .busy_o(busy), .done_o(done),
        .result_o(result), .overflow_o(overflow), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        rd;
        logic [15:0] din;
        logic [4:0]  cnt;
        logic [15:0] dout;
        logic        empty;
        logic        ovf;
    } vec_t;

    vec_t tbl[36];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {spare_struct, bira_clr, bist_start, bist_abort, sol_dout, sol_empty,
                     sol_count, busy, done, result, overflow, timeout_err},
              {2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    endtask

    task automatic wait_clr();
        int n = 0;
        while (!bira_clr && n < 12) begin
            tick();
            n++;
        end
        check("clr_seen", bira_clr, 1'b1);
    endtask

    // Drives one structure through BIST (test_end after delay cycles) and analysis.
    task automatic run_struct(input logic [1:0] exp_s, input int delay,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic rep);
        wait_clr();
        check("spare_struct", spare_struct, exp_s);
        check("busy_in_clear", busy, 1'b1);
        tick();
        check("bist_start", bist_start, 1'b1);
        check("clr_one_cycle", bira_clr, 1'b0);
        tick();
        check("bist_start_one_cycle", bist_start, 1'b0);
        repeat (delay - 1) tick();
        test_end = 1'b1;
        tick();
        test_end = 1'b0;
        sol_valid = 1'b1;
        solution = w0; tick();
        solution = w1; tick();
        solution = w2; tick();
        sol_valid = 1'b0;
        ra_done = 1'b1;
        repair = rep;
        tick();
        ra_done = 1'b0;
        repair = 1'b0;
        check("no_abort", bist_abort, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pops [6];
        int aborts;

        // FIFO table: 18 writes into a 16-deep FIFO, read+write while full, drain.
        for (int k = 0; k < 18; k++) begin
            tbl[k] = '{1'b1, 1'b0, 16'hA000 + 16'(k), (k < 16) ? 5'(k + 1) : 5'd16,
                       16'hA000, 1'b0, (k >= 16)};
        end
        tbl[18] = '{1'b1, 1'b1, 16'hB000, 5'd16, 16'hA001, 1'b0, 1'b1};
        for (int j = 0; j < 16; j++) begin
            tbl[19 + j] = '{1'b0, 1'b1, 16'h0000, 5'(15 - j),
                            (j < 14) ? 16'hA002 + 16'(j) : 16'hB000, (j == 15), 1'b1};
        end
        tbl[35] = '{1'b0, 1'b1, 16'h0000, 5'd0, 16'hB000, 1'b1, 1'b1};

        pops = '{16'h1003, 16'h3005, 16'h5007, 16'h2001, 16'h2002, 16'h2003};

        #1;
        check_reset_vals("reset_state");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_reset_vals("idle_after_reset");

        // Mask 0101, both structures repairable.
        mask = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_select", busy, 1'b1);
        run_struct(2'd0, 20, 16'h1003, 16'h3005, 16'h5007, 1'b1);
        run_struct(2'd2, 20, 16'h2001, 16'h2002, 16'h2003, 1'b1);
        tick();
        check("s1_done", done, 1'b1);
        check("s1_busy", busy, 1'b0);
        check("s1_result", result, 4'b0101);
        check("s1_count", sol_count, 5'd6);
        for (int i = 0; i < 6; i++) begin
            check("s1_pop", sol_dout, pops[i]);
            sol_rd = 1'b1;
            tick();
        end
        check("s1_empty", sol_empty, 1'b1);
        tick();
        sol_rd = 1'b0;
        check("s1_rd_empty_count", sol_count, 5'd0);
        check("s1_dout_hold", sol_dout, 16'h2003);

        // Mask 0010, early_term together with test_end.
        mask = 4'b0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_clr();
        check("s2_spare", spare_struct, 2'd1);
        tick();
        repeat (5) tick();
        early_term = 1'b1;
        test_end = 1'b1;
        tick();
        early_term = 1'b0;
        test_end = 1'b0;
        check("s2_abort", bist_abort, 1'b1);
        tick();
        check("s2_abort_one", bist_abort, 1'b0);
        check("s2_done", done, 1'b1);
        check("s2_result", result, 4'b0000);
        check("s2_no_clr", bira_clr, 1'b0);

        // FIFO table vectors.
        for (int v = 0; v < 36; v++) begin
            sol_valid = tbl[v].vld;
            sol_rd = tbl[v].rd;
            solution = tbl[v].din;
            tick();
            check("fifo_count", sol_count, tbl[v].cnt);
            check("fifo_dout", sol_dout, tbl[v].dout);
            check("fifo_empty", sol_empty, tbl[v].empty);
            check("fifo_ovf", overflow, tbl[v].ovf);
        end
        sol_valid = 1'b0;
        sol_rd = 1'b0;

        // Mask 1000, BIST never ends: timeout.
        sol_valid = 1'b1;
        solution = 16'hCAFE;
        tick();
        sol_valid = 1'b0;
        check("s4_pre_count", sol_count, 5'd1);
        mask = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s4_fifo_cleared", sol_count, 5'd0);
        check("s4_ovf_cleared", overflow, 1'b0);
        wait_clr();
        check("s4_spare", spare_struct, 2'd3);
        tick();
        check("s4_bist_start", bist_start, 1'b1);
        aborts = 0;
        repeat (TMO - 2) begin
            tick();
            if (bist_abort) aborts++;
        end
        check("s4_abort_early", aborts, 0);
        tick();
        check("s4_abort", bist_abort, 1'b1);
        check("s4_tmo", timeout_err, 1'b1);
        tick();
        check("s4_done", done, 1'b1);
        check("s4_result", result, 4'b0000);
        check("s4_tmo_sticky", timeout_err, 1'b1);

        // Busy start ignored: mask 0101 latched, later start with 0010 is not.
        mask = 4'b0101;
        start = 1'b1;
        tick();
        mask = 4'b0010;
        tick();
        start = 1'b0;
        check("s6_spare_kept", spare_struct, 2'd0);
        check("s6_tmo_cleared", timeout_err, 1'b0);
        run_struct(2'd0, 4, 16'h0101, 16'h0102, 16'h0103, 1'b0);
        run_struct(2'd2, 4, 16'h0201, 16'h0202, 16'h0203, 1'b1);
        tick();
        check("s6_done", done, 1'b1);
        check("s6_result", result, 4'b0100);

        // Mask 0: straight to DONE, result cleared, no BIST.
        mask = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s6_m0_done", done, 1'b1);
        check("s6_m0_result", result, 4'b0000);
        check("s6_m0_count", sol_count, 5'd0);
        tick();
        check("s6_m0_no_bist", {bist_start, bira_clr, busy}, 3'b000);

        // Reset in the middle of WAIT_RA, then a fresh session.
        mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_clr();
        tick();
        repeat (3) tick();
        test_end = 1'b1;
        tick();
        test_end = 1'b0;
        sol_valid = 1'b1;
        solution = 16'h7777;
        tick();
        sol_valid = 1'b0;
        check("s5_pre_count", sol_count, 5'd1);
        ra_done = 1'b1;
        repair = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("s5_reset_async");
        tick();
        check_reset_vals("s5_reset_hold1");
        tick();
        check_reset_vals("s5_reset_hold2");
        ra_done = 1'b0;
        repair = 1'b0;
        rst_n = 1'b1;
        tick();
        check_reset_vals("s5_after_release");
        mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_struct(2'd0, 8, 16'h0011, 16'h0012, 16'h0013, 1'b1);
        tick();
        check("s5_done", done, 1'b1);
        check("s5_result", result, 4'b0001);
        check("s5_count", sol_count, 5'd3);
        check("s5_head", sol_dout, 16'h0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
